// File: rtl/nat_pkg.sv
// rtl/nat_pkg.sv - shared NAT datapath types, tuple layout and the connection hash fold
package nat_pkg;

    localparam int TUPLE_W = 128;
    localparam int KEY_W   = 104;
    localparam int CONN_W  = 16;
    localparam logic [CONN_W-1:0] CONN_FULL = 16'hFFFF;

    // Bit offsets of the 5-tuple fields inside the parser's tuple word
    localparam int PROTO_LSB  = 0;
    localparam int DPORT_LSB  = 8;
    localparam int SPORT_LSB  = 24;
    localparam int DST_IP_LSB = 40;
    localparam int SRC_IP_LSB = 72;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HASH,
        ST_READ,
        ST_CMP,
        ST_RESP,
        ST_HOLD
    } conn_state_t;

    // Zero-extend the key to 112 bits and XOR its seven 16-bit slices
    function automatic logic [15:0] hash_fold(input logic [KEY_W-1:0] key);
        logic [111:0] ext;
        logic [15:0]  h;
        ext = {8'h00, key};
        h   = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            h = h ^ ext[i*16 +: 16];
        end
        return h;
    endfunction

endpackage

// File: rtl/conn_key_ram.sv
// rtl/conn_key_ram.sv - single-port key RAM with synchronous read and write enable
module conn_key_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 104,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/conn_table.sv
// rtl/conn_table.sv - hashed linear-probing connection lookup/insert returning a slot ID
module conn_table
    import nat_pkg::*;
#(
    parameter int HASH_LEN = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TUPLE_W-1:0]  tuple_data_i,
    input  logic                tuple_valid_i,
    output logic [CONN_W-1:0]   conn_data_o,
    output logic                conn_valid_o,
    output logic                full_o,
    output logic [HASH_LEN:0]   conn_count_o
);

    localparam int DEPTH = 1 << HASH_LEN;

    conn_state_t          state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [HASH_LEN-1:0]  idx_q, idx_d;
    logic [HASH_LEN:0]    probes_q, probes_d;
    logic [HASH_LEN:0]    count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [CONN_W-1:0]    result_q, result_d;
    logic [CONN_W-1:0]    conn_data_q, conn_data_d;
    logic                 conn_valid_q, conn_valid_d;

    logic [KEY_W-1:0]     rd_key;
    logic                 ram_we;
    logic [HASH_LEN-1:0]  start_idx;
    logic [HASH_LEN:0]    probes_inc;
    logic                 unused_tuple_hi;

    assign unused_tuple_hi = ^tuple_data_i[TUPLE_W-1:KEY_W];
    assign start_idx       = HASH_LEN'(hash_fold(key_q));
    assign probes_inc      = probes_q + (HASH_LEN+1)'(1);

    // A write still pending while reset is asserted must never reach the RAM
    conn_key_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (KEY_W),
        .ADDR_W (HASH_LEN)
    ) u_key_ram (
        .clk   (clk),
        .we    (ram_we & ~reset),
        .addr  (idx_q),
        .wdata (key_q),
        .rdata (rd_key)
    );

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        idx_d        = idx_q;
        probes_d     = probes_q;
        count_d      = count_q;
        valid_d      = valid_q;
        result_d     = result_q;
        conn_data_d  = conn_data_q;
        conn_valid_d = 1'b0;
        ram_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tuple_valid_i) begin
                    key_d   = tuple_data_i[KEY_W-1:0];
                    state_d = ST_HASH;
                end
            end
            ST_HASH: begin
                idx_d    = start_idx;
                probes_d = '0;
                state_d  = ST_READ;
            end
            ST_READ: state_d = ST_CMP;
            ST_CMP: begin
                if (valid_q[idx_q] && (rd_key == key_q)) begin
                    result_d = CONN_W'(idx_q);
                    state_d  = ST_RESP;
                end else if (!valid_q[idx_q]) begin
                    ram_we         = 1'b1;
                    valid_d[idx_q] = 1'b1;
                    count_d        = count_q + (HASH_LEN+1)'(1);
                    result_d       = CONN_W'(idx_q);
                    state_d        = ST_RESP;
                end else begin
                    probes_d = probes_inc;
                    if (probes_inc == (HASH_LEN+1)'(DEPTH)) begin
                        result_d = CONN_FULL;
                        state_d  = ST_RESP;
                    end else begin
                        idx_d   = idx_q + HASH_LEN'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_RESP: begin
                conn_valid_d = 1'b1;
                conn_data_d  = result_q;
                state_d      = ST_HOLD;
            end
            // Wait for the parser to drop its request so it is served only once
            ST_HOLD: begin
                if (!tuple_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            idx_q        <= '0;
            probes_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            result_q     <= '0;
            conn_data_q  <= '0;
            conn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            idx_q        <= idx_d;
            probes_q     <= probes_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            conn_data_q  <= conn_data_d;
            conn_valid_q <= conn_valid_d;
        end
    end

    assign conn_data_o  = conn_data_q;
    assign conn_valid_o = conn_valid_q;
    assign conn_count_o = count_q;
    assign full_o       = (count_q == (HASH_LEN+1)'(DEPTH));

endmodule

// File: tb/tb_conn_table.sv
// tb/tb_conn_table.sv - directed self-checking bench for conn_table
module tb_conn_table;

    localparam int HL = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [127:0]  tuple_data_i;
    logic          tuple_valid_i;
    logic [15:0]   conn_data_o;
    logic          conn_valid_o;
    logic          full_o;
    logic [HL:0]   conn_count_o;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [103:0] KEY_A = {32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h06};
    localparam logic [103:0] KEY_B = {32'h0A000001, 32'h0A000002, 16'h1274, 16'h0050, 8'h06};

    always #5 clk = ~clk;

    conn_table #(.HASH_LEN(HL)) dut (
        .clk           (clk),
        .reset         (reset),
        .tuple_data_i  (tuple_data_i),
        .tuple_valid_i (tuple_valid_i),
        .conn_data_o   (conn_data_o),
        .conn_valid_o  (conn_valid_o),
        .full_o        (full_o),
        .conn_count_o  (conn_count_o)
    );

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b1;
        tuple_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // lat = number of edges after the first sampling edge until conn_valid_o shows; -1 on timeout
    task automatic do_req(input logic [103:0] key, output logic [15:0] data, output int lat);
        int n;
        bit got;
        @(negedge clk);
        tuple_data_i  = {24'h0, key};
        tuple_valid_i = 1'b1;
        got  = 1'b0;
        lat  = -1;
        data = 16'h0;
        @(posedge clk);
        n = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            if (conn_valid_o) begin
                got  = 1'b1;
                lat  = n;
                data = conn_data_o;
            end else begin
                @(posedge clk);
                n++;
            end
        end
        tuple_valid_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset();
        tests_run++; if (conn_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset conn_valid: got %b expected 0", conn_valid_o); end
        tests_run++; if (conn_data_o !== 16'h0) begin tests_failed++; $display("FAIL reset conn_data: got %h expected 0000", conn_data_o); end
        tests_run++; if (full_o !== 1'b0) begin tests_failed++; $display("FAIL reset full: got %b expected 0", full_o); end
        tests_run++; if (conn_count_o !== 7'd0) begin tests_failed++; $display("FAIL reset count: got %0d expected 0", conn_count_o); end
    endtask

    task automatic test_insert_a;
        logic [15:0] d;
        int lat;
        do_req(KEY_A, d, lat);
        tests_run++; if (d !== 16'h0014) begin tests_failed++; $display("FAIL insert_a data: got %h expected 0014", d); end
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL insert_a latency: got %0d expected 4", lat); end
        tests_run++; if (conn_count_o !== 7'd1) begin tests_failed++; $display("FAIL insert_a count: got %0d expected 1", conn_count_o); end
        repeat (5) @(negedge clk);
        tests_run++; if (conn_data_o !== 16'h0014) begin tests_failed++; $display("FAIL insert_a data_hold: got %h expected 0014", conn_data_o); end
    endtask

    task automatic test_hit_a;
        logic [15:0] d;
        int lat;
        do_req(KEY_A, d, lat);
        tests_run++; if (d !== 16'h0014) begin tests_failed++; $display("FAIL hit_a data: got %h expected 0014", d); end
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL hit_a latency: got %0d expected 4", lat); end
        tests_run++; if (conn_count_o !== 7'd1) begin tests_failed++; $display("FAIL hit_a count: got %0d expected 1", conn_count_o); end
    endtask

    task automatic test_collision_b;
        logic [15:0] d;
        int lat;
        do_req(KEY_B, d, lat);
        tests_run++; if (d !== 16'h0015) begin tests_failed++; $display("FAIL collision_b data: got %h expected 0015", d); end
        tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL collision_b latency: got %0d expected 6", lat); end
        tests_run++; if (conn_count_o !== 7'd2) begin tests_failed++; $display("FAIL collision_b count: got %0d expected 2", conn_count_o); end
    endtask

    task automatic test_hold;
        int pulses;
        int seen_at;
        @(negedge clk);
        tuple_data_i  = {24'h0, KEY_A};
        tuple_valid_i = 1'b1;
        pulses  = 0;
        seen_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (conn_valid_o) begin
                pulses++;
                if (seen_at < 0) seen_at = c;
            end
            if (seen_at >= 0 && c == seen_at + 10) tuple_valid_i = 1'b0;
        end
        tuple_valid_i = 1'b0;
        tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL hold pulses: got %0d expected 1", pulses); end
        tests_run++; if (conn_data_o !== 16'h0014) begin tests_failed++; $display("FAIL hold data: got %h expected 0014", conn_data_o); end
    endtask

    task automatic test_reset_mid_probe;
        int pulses;
        logic [15:0] d;
        int lat;
        @(negedge clk);
        tuple_data_i  = {24'h0, KEY_B};
        tuple_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tuple_valid_i = 1'b0;
        pulses = 0;
        @(negedge clk);
        if (conn_valid_o) pulses++;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (conn_valid_o) pulses++;
        end
        tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL midreset pulses: got %0d expected 0", pulses); end
        tests_run++; if (conn_count_o !== 7'd0) begin tests_failed++; $display("FAIL midreset count: got %0d expected 0", conn_count_o); end
        do_req(KEY_A, d, lat);
        tests_run++; if (d !== 16'h0014) begin tests_failed++; $display("FAIL midreset reinsert data: got %h expected 0014", d); end
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL midreset reinsert latency: got %0d expected 4", lat); end
        tests_run++; if (conn_count_o !== 7'd1) begin tests_failed++; $display("FAIL midreset reinsert count: got %0d expected 1", conn_count_o); end
    endtask

    // Key 63 hashes to slot 63; 0x0040_007F folds to 0x0040^0x007F = 0x003F as well
    task automatic test_wrap;
        logic [15:0] d;
        int lat;
        apply_reset();
        do_req(104'd63, d, lat);
        tests_run++; if (d !== 16'h003F) begin tests_failed++; $display("FAIL wrap x data: got %h expected 003f", d); end
        do_req(104'h0040_007F, d, lat);
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL wrap y data: got %h expected 0000", d); end
        tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL wrap y latency: got %0d expected 6", lat); end
        tests_run++; if (conn_count_o !== 7'd2) begin tests_failed++; $display("FAIL wrap count: got %0d expected 2", conn_count_o); end
    endtask

    // Keys 0..63 each hash straight to their own slot; key 0x10000 folds to 0x0001
    task automatic test_fill;
        logic [15:0] d;
        int lat;
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            do_req(104'(i), d, lat);
            tests_run++; if (d !== 16'(i)) begin tests_failed++; $display("FAIL fill slot %0d: got %h expected %h", i, d, 16'(i)); end
            if (i == 62) begin
                tests_run++; if (full_o !== 1'b0) begin tests_failed++; $display("FAIL fill full_early: got %b expected 0", full_o); end
            end
        end
        tests_run++; if (full_o !== 1'b1) begin tests_failed++; $display("FAIL fill full: got %b expected 1", full_o); end
        tests_run++; if (conn_count_o !== 7'd64) begin tests_failed++; $display("FAIL fill count: got %0d expected 64", conn_count_o); end
        do_req(104'h1_0000, d, lat);
        tests_run++; if (d !== 16'hFFFF) begin tests_failed++; $display("FAIL overflow data: got %h expected ffff", d); end
        tests_run++; if (lat !== 130) begin tests_failed++; $display("FAIL overflow latency: got %0d expected 130", lat); end
        tests_run++; if (conn_count_o !== 7'd64) begin tests_failed++; $display("FAIL overflow count: got %0d expected 64", conn_count_o); end
        do_req(104'd37, d, lat);
        tests_run++; if (d !== 16'h0025) begin tests_failed++; $display("FAIL full hit data: got %h expected 0025", d); end
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL full hit latency: got %0d expected 4", lat); end
    endtask

    initial begin
        reset         = 1'b1;
        tuple_valid_i = 1'b0;
        tuple_data_i  = '0;
        test_reset();
        test_insert_a();
        test_hit_a();
        test_collision_b();
        test_hold();
        test_reset_mid_probe();
        test_wrap();
        test_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conn_table.md
# conn_table

Connection-lookup stage paired with the 5-tuple parser on the AXIS NAT datapath. It accepts the 128-bit tuple the parser raises while the parser stalls the stream. It hashes the tuple into a 2^HASH_LEN-entry table using linear probing, then returns a connection ID. On a hit the ID is the existing slot index; on a miss the tuple is inserted and the new slot index is returned. The parser writes the ID into the packet's port field and releases the stream.

## Interface
- HASH_LEN, 6: table index width; legal range 1..16; table depth 2^HASH_LEN.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears state and all table valid bits.
- tuple_data_i  in  128  {24'h0, src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], protocol[7:0]}; bits [127:104] ignored.
- tuple_valid_i  in  1  level request; held high by parser until conn_valid_o seen.
- conn_data_o  out  16  zero-extended slot index, or 16'hFFFF when table full.
- conn_valid_o  out  1  one-cycle response pulse.
- full_o  out  1  high while all 2^HASH_LEN slots are valid.
- conn_count_o  out  HASH_LEN+1  number of valid slots.

## Operation
- Key K = tuple_data_i[103:0], captured into a register.
- Hash: zero-extend K to 112 bits; XOR the seven 16-bit slices to get h; start index = h[HASH_LEN-1:0].
- Table: key RAM of 2^HASH_LEN × 104 bits with synchronous read and write; separate valid-bit flop vector so reset clears it in one cycle.
- FSM states:
  - IDLE: when tuple_valid_i=1, capture K and go to HASH.
  - HASH: register idx=start index, probes=0, go to READ.
  - READ: present idx to RAM, go to CMP.
  - CMP: evaluate the slot at idx.
    - Slot valid and key equal (hit): result=idx, go to RESP.
    - Slot not valid: write K at idx, set valid[idx], count+1, result=idx, go to RESP.
    - Otherwise: probes+1; if probes+1 == 2^HASH_LEN, result=16'hFFFF and go to RESP; else idx=idx+1 (wraps modulo 2^HASH_LEN), go to READ.
  - RESP: conn_valid_o=1, conn_data_o=result, go to HOLD.
  - HOLD: return to IDLE once tuple_valid_i=0. This prevents re-serving a held request.
- Entries are never deleted; there is no aging.
- full_o = (conn_count_o == 2^HASH_LEN), combinational from count.
- conn_data_o holds its last value between pulses.

## Timing
- Reset values: conn_valid_o=0, conn_data_o=0, full_o=0, conn_count_o=0, FSM=IDLE, all valid bits 0.
- Latency, counted from the first cycle tuple_valid_i is sampled high (edge 0) with a first-probe resolve: conn_valid_o is high in the cycle after edge 4.
  - Each additional probe adds 2 cycles.
  - Full-table miss: 4 + 2·(2^HASH_LEN − 1) edges.
- The parser drops tuple_valid_i on the edge that samples conn_valid_o. HOLD then exits one cycle later, so back-to-back requests are spaced ≥6 cycles.
- tuple_valid_i changes while not in IDLE/HOLD are ignored; the captured K is used.
- Reset asserted mid-probe: the FSM returns to IDLE, any pending write is dropped, and no conn_valid_o pulse is issued. The parser is reset in the same cycle.
- Index increment wraps from 2^HASH_LEN−1 to 0.

## Structure
- Shared package `nat_pkg`:
  - TUPLE_W=128, KEY_W=104, CONN_W=16, CONN_FULL=16'hFFFF.
  - FSM state enum.
  - Tuple field offsets, shared with the parser.
- One sub-module, `conn_key_ram`: parameterized depth/width, single port, synchronous read, write-enable. Valid bits stay in `conn_table` itself.
- Hash fold is a function in `nat_pkg` so the bench model reuses it.

## Test plan
- Reset, then tuple A (src 0x0A000001, dst 0x0A000002, sport 0x1234, dport 0x0050, proto 0x06) -> h=0x6714, conn_data_o=0x0014 after 5 cycles, conn_count_o=1.
- Request A again -> conn_data_o=0x0014 at the same latency, conn_count_o stays 1.
- Tuple B = A with sport 0x1274 (collides at index 20) -> probes 20 then 21; conn_data_o=0x0015 at 7-cycle latency, count=2.
- Insert 64 distinct tuples, then a 65th -> full_o=1 after the 64th; 65th returns 16'hFFFF after 4+2·63 edges, count stays 64. A repeat of any stored tuple still hits.
- Index wrap: fill slot 63 with key X, then a key hashing to 63 -> returns 0x0000.
- Hold tuple_valid_i high 10 cycles after the pulse -> exactly one conn_valid_o pulse. Separately, assert reset during READ -> no pulse, count=0, and A afterwards re-inserts at 0x0014.
